// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states, legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RMW_RD,
    ST_LOAD,
    ST_STORE,
    ST_RESP
  } state_t;

  // True when the width code, alignment and word index are all acceptable.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [31:0] addr, input int unsigned mem_words);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr[0];
      F3_W:    ok = (addr[1:0] == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok && ((addr >> 2) < 32'(mem_words));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: extract/extend a load lane and merge a sub-word store into a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  assign sh = {off, 3'b000};

  // Load side: shift the addressed lane down and extend it to 32 bits.
  always_comb begin
    lane = 16'(rdata >> sh);
    ext  = rdata;
    case (funct3)
      F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   ext = {24'h0, lane[7:0]};
      F3_HU:   ext = {16'h0, lane[15:0]};
      default: ext = rdata;
    endcase
  end

  // Store side: replace only the addressed byte/halfword, keep the rest of the old word.
  always_comb begin
    mask   = funct3[0] ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
    merged = (rdata & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Core-side load/store initiator for a single-port word-indexed data memory.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic [31:0] ext;
  logic [31:0] merged;

  lsu_lane_align u_align (
    .rdata  (mem_rdata),
    .wdata  (lat_wdata),
    .funct3 (lat_f3),
    .off    (lat_off),
    .ext    (ext),
    .merged (merged)
  );

  // FSM with request latch, memory strobes and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_f3    <= req_funct3;
            lat_off   <= req_addr[1:0];
            lat_wdata <= req_wdata;
            mem_addr  <= 32'(req_addr >> 2);
            mem_wdata <= req_wdata;
            if (!is_legal(req_we, req_funct3, req_addr, MEM_WORDS)) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (!req_we) begin
              mem_re <= 1'b1;
              state  <= ST_LOAD;
            end else if (req_funct3 == F3_W) begin
              mem_we <= 1'b1;
              state  <= ST_STORE;
            end else begin
              mem_re <= 1'b1;
              state  <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          mem_re    <= 1'b0;
          rsp_rdata <= ext;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
          state     <= ST_STORE;
        end
        ST_STORE: begin
          mem_we    <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a byte-level reference memory.
module tb_lsu_mem_initiator;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_mem_initiator #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT: combinational read, write on rising edge.
  logic [31:0] mem [64];
  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t_acc;
    int          re_tot;
    int          we_tot;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int   re_cnt = 0;
  int   we_cnt = 0;
  int   hs_cyc = 0;

  // Reference model state: byte-addressed image of the 256-byte memory.
  logic [7:0] mb [256];
  int m_re = 0;
  int m_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural behaviour of one request in terms of bytes and sizes.
  task automatic model_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output bit err, output int lat);
    int  size;
    bit  legal;
    logic [31:0] v;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    rd = 32'h0;
    err = 1'b0;
    if (!legal || (a % size) != 0 || a >= 32'd256) begin
      err = 1'b1;
      lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(mb[int'(a) + k]) << (8 * k));
      if (size < 4 && f3[2] == 1'b0 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rd = v;
      m_re++;
      lat = 2;
    end else begin
      for (int k = 0; k < size; k++) mb[int'(a) + k] = wd[8 * k +: 8];
      if (size == 4) lat = 2;
      else begin
        m_re++;
        lat = 3;
      end
      m_we++;
    end
  endtask

  // Drive one request; optionally push its expected response to the scoreboard.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit push,
                        output logic [31:0] exp_rd, output int t_acc);
    int   n;
    bit   e_err;
    int   e_lat;
    exp_t e;
    n = 0;
    exp_rd = 32'h0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        t_acc = cyc;
        return;
      end
    end
    t_acc = cyc;
    if (push) begin
      model_req(we, f3, a, wd, exp_rd, e_err, e_lat);
      e.rdata = exp_rd; e.err = e_err; e.lat = e_lat; e.t_acc = t_acc;
      e.re_tot = m_re; e.we_tot = m_we;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 || rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: drives rsp_ready, counts memory strobes, checks each response.
  initial begin
    bit   seen;
    int   first;
    exp_t e;
    seen = 0;
    first = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
        if (mem_re || mem_we) chk("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
        if (rsp_valid && !seen) begin
          seen = 1;
          first = cyc;
        end
        if (rsp_valid && rsp_ready) begin
          hs_cyc = cyc;
          seen = 0;
          if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_latency", 32'(first - e.t_acc), 32'(e.lat));
            chk("mem_re_count", 32'(re_cnt), 32'(e.re_tot));
            chk("mem_we_count", 32'(we_cnt), 32'(e.we_tot));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd, rd5;
    int          ta, ta2;
    int          n;
    logic [31:0] w, a;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [6];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5; legal_f3[5] = 3'd2;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) mb[i] = 8'h0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // 1) SW then LW
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 1, rd, ta);
    wait_idle();
    chk("sw_word4", mem[4], 32'hDEADBEEF);
    do_req(0, 3'd2, 32'h10, 32'h0, 1, rd, ta);

    // 2) SB read-modify-write
    do_req(1, 3'd0, 32'h11, 32'h55, 1, rd, ta);
    wait_idle();
    chk("sb_word4", mem[4], 32'hDEAD55EF);

    // 3) Sub-word loads with sign and zero extension
    do_req(0, 3'd0, 32'h13, 32'h0, 1, rd, ta);
    do_req(0, 3'd4, 32'h13, 32'h0, 1, rd, ta);
    do_req(0, 3'd1, 32'h12, 32'h0, 1, rd, ta);
    do_req(0, 3'd5, 32'h10, 32'h0, 1, rd, ta);

    // 4) Errors: misaligned, out of range, illegal funct3, store with BU
    do_req(0, 3'd2, 32'h12, 32'h0, 1, rd, ta);
    do_req(1, 3'd2, 32'h100, 32'h12345678, 1, rd, ta);
    do_req(0, 3'd3, 32'h0, 32'h0, 1, rd, ta);
    do_req(1, 3'd4, 32'h20, 32'hFF, 1, rd, ta);
    do_req(1, 3'd2, 32'hFC, 32'hCAFEF00D, 1, rd, ta);
    do_req(0, 3'd2, 32'hFC, 32'h0, 1, rd, ta);
    wait_idle();

    // 5) Back-pressure with a request waiting behind the stalled response
    rdy_mode = 2;
    do_req(0, 3'd2, 32'h10, 32'h0, 1, rd5, ta);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    fork
      begin
        do_req(0, 3'd0, 32'h13, 32'h0, 1, rd, ta2);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
          chk("bp_rsp_rdata", rsp_rdata, rd5);
          chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        rdy_mode = 0;
      end
    join
    chk("bp_accept_after_rsp", 32'(ta2 > hs_cyc), 32'd1);
    wait_idle();

    // 6) Reset during the STORE cycle drops the request
    do_req(1, 3'd2, 32'h40, 32'hA5A5A5A5, 0, rd, ta);
    chk("st_mem_we_before_reset", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("st_rst_mem_we", 32'(mem_we), 32'd0);
    chk("st_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("st_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 3'd2, 32'h40, 32'h0, 1, rd, ta);
    wait_idle();

    // Randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom % 8)
        0: w = 32'd63;
        1: w = 32'd64 + 32'($urandom % 4);
        2: w = $urandom;
        default: w = 32'($urandom % 64);
      endcase
      a = (w << 2) | 32'($urandom % 4);
      f3 = ($urandom % 8 < 6) ? legal_f3[$urandom % 6] : 3'($urandom % 8);
      do_req(1'($urandom % 2), f3, a, $urandom, 1, rd, ta);
    end
    wait_idle();
    rdy_mode = 0;

    // Final memory image against the reference bytes
    for (int i = 0; i < 64; i++)
      chk($sformatf("mem_word_%0d", i), mem[i],
          {mb[4 * i + 3], mb[4 * i + 2], mb[4 * i + 1], mb[4 * i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
